// File: rtl/selen_wb_pkg.sv
// Shared types and defaults for the Selen Wishbone two-master arbiter.
package selen_wb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // When both masters request at once, the one that did not own the bus last wins.
  function automatic arb_state_e tie_winner(input arb_owner_e last_owner);
    if (last_owner == OWN_D) begin
      return ARB_GNT_I;
    end else begin
      return ARB_GNT_D;
    end
  endfunction

endpackage

// File: rtl/selen_wb_arb_timer.sv
// Stall watchdog for the arbiter: counts cycles the owner's strobe waits for
// a slave response and raises a single-cycle expire pulse at TIMEOUT.
module selen_wb_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic s_cyc,
  input  logic owner_stb,
  input  logic s_ack,
  input  logic s_err,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_r;

  // Expiry looks only at the counter and the master strobe, never at s_ack,
  // so a slave that acks combinationally from s_stb cannot form a loop.
  assign expire = s_cyc & owner_stb & (count_r == CNT_W'(TIMEOUT - 1));

  // Wait-cycle counter: cleared by any response, by release and by expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (!s_cyc || s_ack || s_err || expire) begin
      count_r <= {CNT_W{1'b0}};
    end else if (owner_stb) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/selen_wb_arbiter.sv
// Two-master (instruction / data) to one-slave classic Wishbone arbiter.
// Round-robin on simultaneous requests, grant held for the owner's whole cycle.
// Optional stall watchdog enabled by defining SELEN_WB_ARB_TIMEOUT_EN.
module selen_wb_arbiter
  import selen_wb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  // instruction master
  input  logic                i_cyc,
  input  logic                i_stb,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_adr,
  input  logic [DATA_W-1:0]   i_dat_w,
  input  logic [DATA_W/8-1:0] i_sel,
  output logic                i_ack,
  output logic                i_err,
  output logic [DATA_W-1:0]   i_dat_r,
  // data master
  input  logic                d_cyc,
  input  logic                d_stb,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_adr,
  input  logic [DATA_W-1:0]   d_dat_w,
  input  logic [DATA_W/8-1:0] d_sel,
  output logic                d_ack,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_dat_r,
  // slave
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_dat_w,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic                s_ack,
  input  logic                s_err,
  input  logic [DATA_W-1:0]   s_dat_r
);

  localparam int SEL_W = DATA_W / 8;

  // The watchdog compares against TIMEOUT-1, so it needs at least two cycles.
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("selen_wb_arbiter: TIMEOUT must be at least 2");
  end

  arb_state_e state_r;
  arb_state_e next_state;
  arb_owner_e last_owner_r;
  logic       owner_stb;
  logic       expire;

  // Strobe of whichever master currently holds the grant.
  always_comb begin
    owner_stb = 1'b0;
    case (state_r)
      ARB_GNT_I: owner_stb = i_stb;
      ARB_GNT_D: owner_stb = d_stb;
      default:   owner_stb = 1'b0;
    endcase
  end

`ifdef SELEN_WB_ARB_TIMEOUT_EN
  selen_wb_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .s_cyc     (s_cyc),
    .owner_stb (owner_stb),
    .s_ack     (s_ack),
    .s_err     (s_err),
    .expire    (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // Grant state and round-robin history; last owner updates on every release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ARB_IDLE;
      last_owner_r <= OWN_D;
    end else begin
      state_r <= next_state;
      if ((state_r == ARB_GNT_I) && !i_cyc) begin
        last_owner_r <= OWN_I;
      end else if ((state_r == ARB_GNT_D) && !d_cyc) begin
        last_owner_r <= OWN_D;
      end else begin
        last_owner_r <= last_owner_r;
      end
    end
  end

  // Next grant: hold while the owner keeps cyc, hand over directly on release.
  always_comb begin
    next_state = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (i_cyc && d_cyc) begin
          next_state = tie_winner(last_owner_r);
        end else if (i_cyc) begin
          next_state = ARB_GNT_I;
        end else if (d_cyc) begin
          next_state = ARB_GNT_D;
        end else begin
          next_state = ARB_IDLE;
        end
      end
      ARB_GNT_I: begin
        if (i_cyc) begin
          next_state = ARB_GNT_I;
        end else if (d_cyc) begin
          next_state = ARB_GNT_D;
        end else begin
          next_state = ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        if (d_cyc) begin
          next_state = ARB_GNT_D;
        end else if (i_cyc) begin
          next_state = ARB_GNT_I;
        end else begin
          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // Bus routing: owner drives the slave, slave responses go only to the owner.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = {ADDR_W{1'b0}};
    s_dat_w = {DATA_W{1'b0}};
    s_sel   = {SEL_W{1'b0}};
    i_ack   = 1'b0;
    i_err   = 1'b0;
    i_dat_r = {DATA_W{1'b0}};
    d_ack   = 1'b0;
    d_err   = 1'b0;
    d_dat_r = {DATA_W{1'b0}};
    case (state_r)
      ARB_GNT_I: begin
        s_cyc   = i_cyc;
        s_stb   = i_stb & ~expire;
        s_we    = i_we;
        s_adr   = i_adr;
        s_dat_w = i_dat_w;
        s_sel   = i_sel;
        i_ack   = s_ack;
        i_err   = s_err | expire;
        i_dat_r = s_dat_r;
      end
      ARB_GNT_D: begin
        s_cyc   = d_cyc;
        s_stb   = d_stb & ~expire;
        s_we    = d_we;
        s_adr   = d_adr;
        s_dat_w = d_dat_w;
        s_sel   = d_sel;
        d_ack   = s_ack;
        d_err   = s_err | expire;
        d_dat_r = s_dat_r;
      end
      default: begin
        s_cyc = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_selen_wb_arbiter.sv
// Directed self-checking bench for selen_wb_arbiter (TIMEOUT set to 8).
// Expectations for the watchdog follow SELEN_WB_ARB_TIMEOUT_EN.
module tb_selen_wb_arbiter;
  import selen_wb_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_cyc, i_stb, i_we;
  logic [ADDR_W-1:0] i_adr;
  logic [DATA_W-1:0] i_dat_w;
  logic [3:0]        i_sel;
  logic              i_ack, i_err;
  logic [DATA_W-1:0] i_dat_r;
  logic              d_cyc, d_stb, d_we;
  logic [ADDR_W-1:0] d_adr;
  logic [DATA_W-1:0] d_dat_w;
  logic [3:0]        d_sel;
  logic              d_ack, d_err;
  logic [DATA_W-1:0] d_dat_r;
  logic              s_cyc, s_stb, s_we;
  logic [ADDR_W-1:0] s_adr;
  logic [DATA_W-1:0] s_dat_w;
  logic [3:0]        s_sel;
  logic              s_ack, s_err;
  logic [DATA_W-1:0] s_dat_r;

  int n_checks = 0;
  int n_errors = 0;

  selen_wb_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst (rst),
    .i_cyc (i_cyc), .i_stb (i_stb), .i_we (i_we), .i_adr (i_adr),
    .i_dat_w (i_dat_w), .i_sel (i_sel), .i_ack (i_ack), .i_err (i_err),
    .i_dat_r (i_dat_r),
    .d_cyc (d_cyc), .d_stb (d_stb), .d_we (d_we), .d_adr (d_adr),
    .d_dat_w (d_dat_w), .d_sel (d_sel), .d_ack (d_ack), .d_err (d_err),
    .d_dat_r (d_dat_r),
    .s_cyc (s_cyc), .s_stb (s_stb), .s_we (s_we), .s_adr (s_adr),
    .s_dat_w (s_dat_w), .s_sel (s_sel), .s_ack (s_ack), .s_err (s_err),
    .s_dat_r (s_dat_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs change here.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 32'h40;
    i_dat_w = 32'h0; i_sel = 4'hF;
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_adr = 32'h80;
    d_dat_w = 32'h0; d_sel = 4'hF;
    s_ack = 1'b1; s_err = 1'b0; s_dat_r = 32'h1234_5678;

    // 1: reset with both masters requesting and a stray slave ack
    repeat (2) next_cycle();
    #1;
    check("rst_state", 64'(dut.state_r), 64'(ARB_IDLE));
    check("rst_s_cyc", 64'(s_cyc), 64'h0);
    check("rst_s_stb", 64'(s_stb), 64'h0);
    check("rst_s_adr", 64'(s_adr), 64'h0);
    check("rst_i_ack", 64'(i_ack), 64'h0);
    check("rst_d_ack", 64'(d_ack), 64'h0);
    check("rst_i_dat_r", 64'(i_dat_r), 64'h0);
    next_cycle();
    rst = 1'b1; s_ack = 1'b0;
    #1;
    check("rel_state", 64'(dut.state_r), 64'(ARB_IDLE));
    next_cycle();
    #1;
    check("tie_gnt_i", 64'(dut.state_r), 64'(ARB_GNT_I));
    check("tie_s_cyc", 64'(s_cyc), 64'h1);
    check("tie_s_adr", 64'(s_adr), 64'h40);
    s_ack = 1'b1;
    #1;
    check("tie_i_ack", 64'(i_ack), 64'h1);
    check("tie_i_dat_r", 64'(i_dat_r), 64'h1234_5678);
    check("tie_d_ack", 64'(d_ack), 64'h0);
    check("tie_d_dat_r", 64'(d_dat_r), 64'h0);

    // 2: I releases -> D granted directly; D releases; both re-request -> I
    next_cycle();
    i_cyc = 1'b0; i_stb = 1'b0; s_ack = 1'b0;
    #1;
    check("irel_s_cyc", 64'(s_cyc), 64'h0);
    next_cycle();
    #1;
    check("sw_gnt_d", 64'(dut.state_r), 64'(ARB_GNT_D));
    check("sw_s_adr", 64'(s_adr), 64'h80);
    s_ack = 1'b1;
    #1;
    check("sw_d_ack", 64'(d_ack), 64'h1);
    check("sw_i_ack", 64'(i_ack), 64'h0);
    next_cycle();
    d_cyc = 1'b0; d_stb = 1'b0; s_ack = 1'b0;
    next_cycle();
    i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
    #1;
    check("rr_idle", 64'(dut.state_r), 64'(ARB_IDLE));
    check("rr_idle_s_cyc", 64'(s_cyc), 64'h0);
    next_cycle();
    #1;
    check("rr_gnt_i", 64'(dut.state_r), 64'(ARB_GNT_I));
    s_ack = 1'b1;
    #1;
    check("rr_d_ack", 64'(d_ack), 64'h0);
    check("rr_i_ack", 64'(i_ack), 64'h1);

    // 3: D block of four reads while I keeps requesting
    next_cycle();
    i_cyc = 1'b0; i_stb = 1'b0; s_ack = 1'b0;
    next_cycle();
    i_cyc = 1'b1; i_stb = 1'b1;
    #1;
    check("blk_gnt_d", 64'(dut.state_r), 64'(ARB_GNT_D));
    for (int k = 0; k < 4; k++) begin
      d_adr = 32'h100 + 32'(4 * k);
      s_dat_r = 32'hA0 + 32'(k);
      s_ack = 1'b1;
      #1;
      check("blk_s_adr", 64'(s_adr), 64'h100 + 64'(4 * k));
      check("blk_d_ack", 64'(d_ack), 64'h1);
      check("blk_d_dat_r", 64'(d_dat_r), 64'hA0 + 64'(k));
      check("blk_i_ack", 64'(i_ack), 64'h0);
      next_cycle();
    end
    #1;
    check("blk_hold", 64'(dut.state_r), 64'(ARB_GNT_D));
    d_cyc = 1'b0; d_stb = 1'b0; s_ack = 1'b0;
    next_cycle();
    #1;
    check("blk_to_i", 64'(dut.state_r), 64'(ARB_GNT_I));

    // I releases to idle, then a tie must go to D (last owner was I)
    i_cyc = 1'b0; i_stb = 1'b0;
    next_cycle();
    i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
    next_cycle();
    #1;
    check("rr2_gnt_d", 64'(dut.state_r), 64'(ARB_GNT_D));

    // 4: D write routing
    d_we = 1'b1; d_adr = 32'h2000; d_dat_w = 32'hDEAD_BEEF; d_sel = 4'hF;
    i_adr = 32'h55; i_dat_w = 32'h1111_1111; i_sel = 4'h3;
    s_ack = 1'b1;
    #1;
    check("wr_s_we", 64'(s_we), 64'h1);
    check("wr_s_adr", 64'(s_adr), 64'h2000);
    check("wr_s_dat_w", 64'(s_dat_w), 64'hDEAD_BEEF);
    check("wr_s_sel", 64'(s_sel), 64'hF);
    check("wr_d_ack", 64'(d_ack), 64'h1);
    check("wr_i_ack", 64'(i_ack), 64'h0);
    check("wr_i_err", 64'(i_err), 64'h0);
    s_ack = 1'b0; s_err = 1'b1;
    #1;
    check("wr_d_err", 64'(d_err), 64'h1);
    check("wr_i_err2", 64'(i_err), 64'h0);
    s_err = 1'b0;

    // 5: asynchronous reset in the middle of a pending D strobe
    next_cycle();
    d_we = 1'b0;
    #1;
    check("mid_s_stb", 64'(s_stb), 64'h1);
    rst = 1'b0; s_ack = 1'b1;
    #1;
    check("mid_s_cyc", 64'(s_cyc), 64'h0);
    check("mid_s_stb0", 64'(s_stb), 64'h0);
    check("mid_d_ack", 64'(d_ack), 64'h0);
    check("mid_i_ack", 64'(i_ack), 64'h0);
    check("mid_state", 64'(dut.state_r), 64'(ARB_IDLE));
    next_cycle();
    rst = 1'b1; s_ack = 1'b0;
    d_cyc = 1'b0; d_stb = 1'b0;
    i_cyc = 1'b1; i_stb = 1'b1;

    // 6: slave never responds to I
    next_cycle();
    for (int c = 1; c <= 12; c++) begin
      #1;
`ifdef SELEN_WB_ARB_TIMEOUT_EN
      check("to_i_err", 64'(i_err), (c == TIMEOUT) ? 64'h1 : 64'h0);
      check("to_s_stb", 64'(s_stb), (c == TIMEOUT) ? 64'h0 : 64'h1);
`else
      check("to_i_err", 64'(i_err), 64'h0);
      check("to_s_stb", 64'(s_stb), 64'h1);
`endif
      check("to_d_err", 64'(d_err), 64'h0);
      next_cycle();
    end
    #1;
    check("to_hold", 64'(dut.state_r), 64'(ARB_GNT_I));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
